// File: rtl/wb_mem_arbiter_if.sv
// Wishbone-style request/response link (strb/wr/addr/wdata out, rdata/ack/err back).
// master = requester side, slave = responder side.
interface wb_mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          strb;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          err;

    modport master (output strb, wr, addr, wdata, input rdata, ack, err);
    modport slave  (input strb, wr, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style memory slave between two masters; optional ack watchdog via `WB_ARB_TIMEOUT_EN.
// Latency: 2 edges plus slave latency; all outputs registered, one DONE cycle between transactions.
// Backpressure: masters hold strb until ack; the slave bus is held until s_ack (or watchdog expiry).
module wb_mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    wb_mem_arbiter_if.slave  m0,
    wb_mem_arbiter_if.slave  m1,
    wb_mem_arbiter_if.master s
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t               state, state_nxt;
    logic                 gnt, gnt_nxt;
    logic                 last, last_nxt;
    logic                 win;
    logic                 s_strb_q, s_strb_nxt;
    logic                 s_wr_q, s_wr_nxt;
    logic [AW-1:0]        s_addr_q, s_addr_nxt;
    logic [DW-1:0]        s_wdata_q, s_wdata_nxt;
    logic [1:0]           ack_q, ack_nxt;
    logic [1:0][DW-1:0]   rdata_q, rdata_nxt;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0]        cnt_q, cnt_nxt;
    logic [1:0]           err_q, err_nxt;
    logic                 limit;

    // cnt holds the number of REQ edges already missed, so the limit edge is the TIMEOUT-th one
    assign limit = (cnt_q == CW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        last_nxt    = last;
        s_strb_nxt  = s_strb_q;
        s_wr_nxt    = s_wr_q;
        s_addr_nxt  = s_addr_q;
        s_wdata_nxt = s_wdata_q;
        ack_nxt     = '0;
        rdata_nxt   = rdata_q;
        win         = (m0.strb && m1.strb) ? ~last : m1.strb;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_nxt     = cnt_q;
        err_nxt     = '0;
`endif
        case (state)
            IDLE: begin
                if (m0.strb || m1.strb) begin
                    gnt_nxt     = win;
                    s_strb_nxt  = 1'b1;
                    s_wr_nxt    = win ? m1.wr    : m0.wr;
                    s_addr_nxt  = win ? m1.addr  : m0.addr;
                    s_wdata_nxt = win ? m1.wdata : m0.wdata;
`ifdef WB_ARB_TIMEOUT_EN
                    cnt_nxt     = '0;
`endif
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (s.ack) begin
                    s_strb_nxt   = 1'b0;
                    ack_nxt[gnt] = 1'b1;
                    if (!s_wr_q) rdata_nxt[gnt] = s.rdata;
                    last_nxt     = gnt;
                    state_nxt    = DONE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (limit) begin
                    s_strb_nxt     = 1'b0;
                    ack_nxt[gnt]   = 1'b1;
                    err_nxt[gnt]   = 1'b1;
                    rdata_nxt[gnt] = '0;
                    last_nxt       = gnt;
                    state_nxt      = DONE;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last      <= 1'b1;
            s_strb_q  <= 1'b0;
            s_wr_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= '0;
`endif
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            last      <= last_nxt;
            s_strb_q  <= s_strb_nxt;
            s_wr_q    <= s_wr_nxt;
            s_addr_q  <= s_addr_nxt;
            s_wdata_q <= s_wdata_nxt;
            ack_q     <= ack_nxt;
            rdata_q   <= rdata_nxt;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q     <= cnt_nxt;
            err_q     <= err_nxt;
`endif
        end
    end

    assign s.strb   = s_strb_q;
    assign s.wr     = s_wr_q;
    assign s.addr   = s_addr_q;
    assign s.wdata  = s_wdata_q;
    assign m0.ack   = ack_q[0];
    assign m1.ack   = ack_q[1];
    assign m0.rdata = rdata_q[0];
    assign m1.rdata = rdata_q[1];
`ifdef WB_ARB_TIMEOUT_EN
    assign m0.err   = err_q[0];
    assign m1.err   = err_q[1];
`else
    assign m0.err   = 1'b0;
    assign m1.err   = 1'b0;
`endif
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Scoreboarded bench for wb_mem_arbiter: directed scenarios plus randomized two-master traffic.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;
    localparam int AW = 8, DW = 8, TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_mem_arbiter_if #(.AW(AW), .DW(DW)) m0b ();
    wb_mem_arbiter_if #(.AW(AW), .DW(DW)) m1b ();
    wb_mem_arbiter_if #(.AW(AW), .DW(DW)) sb ();

    wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .m0(m0b), .m1(m1b), .s(sb)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t       exp0[$], exp1[$];
    int         glog[$];
    int         checks = 0, errors = 0, cyc = 0;
    logic [7:0] mem[256], ref_mem[256];
    logic [7:0] last_rdata[2];
    int         slave_mode = 1, fixed_lat = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Issue one transaction from master m and block until its ack (bounded).
    task automatic issue(input int m, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input int lat, input bit to);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        e.err = to;
        e.cyc = (lat >= 0) ? cyc + lat + 2 : -1;
        if (to)      e.rdata = 8'h00;
        else if (wr) e.rdata = last_rdata[m];
        else         e.rdata = ref_mem[addr];
        last_rdata[m] = e.rdata;
        if (wr && !to) ref_mem[addr] = wdata;
        if (m == 0) begin
            exp0.push_back(e);
            m0b.wr = wr; m0b.addr = addr; m0b.wdata = wdata; m0b.strb = 1'b1;
        end else begin
            exp1.push_back(e);
            m1b.wr = wr; m1b.addr = addr; m1b.wdata = wdata; m1b.strb = 1'b1;
        end
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (((m == 0) ? m0b.ack : m1b.ack) === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_wait m%0d: got no ack, required ack within 200 cycles", m);
        end
        if (m == 0) m0b.strb = 1'b0; else m1b.strb = 1'b0;
    endtask

    // Slave memory model with selectable latency; never acks when slave_mode is 0.
    initial begin
        int wait_cnt;
        bit active;
        sb.ack = 1'b0; sb.rdata = '0; sb.err = 1'b0;
        active = 0; wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            sb.ack = 1'b0;
            if (rst && sb.strb === 1'b1 && slave_mode != 0) begin
                if (!active) begin
                    active = 1;
                    wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                end
                if (wait_cnt == 0) begin
                    sb.ack = 1'b1;
                    active = 0;
                    if (sb.wr) begin
                        mem[sb.addr] = sb.wdata;
                        sb.rdata = 8'($urandom);
                    end else begin
                        sb.rdata = mem[sb.addr];
                    end
                end else begin
                    wait_cnt--;
                end
            end else begin
                active = 0;
            end
        end
    end

    // Monitor: grant decision on each s_strb rise, response pops on each master ack.
    logic [1:0] prev_strb;
    logic [7:0] prev_addr[2], prev_wdata[2];
    logic       prev_wr[2];
    logic       prev_s;
    int         last_m = 1, cur_gnt = -1;

    always @(negedge clk) begin
        int   w;
        exp_t e;
        logic a, er;
        logic [7:0] rd;
        if (!rst) begin
            last_m = 1; cur_gnt = -1; prev_s = 1'b0; prev_strb = '0;
        end else begin
            if (sb.strb === 1'b1 && !prev_s) begin
                if (prev_strb == 2'b11)      w = 1 - last_m;
                else if (prev_strb == 2'b01) w = 0;
                else if (prev_strb == 2'b10) w = 1;
                else                         w = -1;
                checks++;
                if (w < 0) begin
                    errors++;
                    $display("FAIL spurious_strb: got s_strb=1 required 0 (no request pending)");
                end else if ({sb.addr, sb.wr, sb.wdata} !== {prev_addr[w], prev_wr[w], prev_wdata[w]}) begin
                    errors++;
                    $display("FAIL grant_m%0d: got addr=%0h wr=%0b wdata=%0h required addr=%0h wr=%0b wdata=%0h",
                             w, sb.addr, sb.wr, sb.wdata, prev_addr[w], prev_wr[w], prev_wdata[w]);
                end
                cur_gnt = w;
                glog.push_back(w);
            end
            for (int n = 0; n < 2; n++) begin
                a  = (n == 0) ? m0b.ack   : m1b.ack;
                er = (n == 0) ? m0b.err   : m1b.err;
                rd = (n == 0) ? m0b.rdata : m1b.rdata;
                if (a === 1'b1) begin
                    checks++;
                    if (n != cur_gnt) begin
                        errors++;
                        $display("FAIL ack_owner: got ack on m%0d required grantee m%0d", n, cur_gnt);
                    end
                    if ((n == 0 ? exp0.size() : exp1.size()) == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack m%0d: got ack required none", n);
                    end else begin
                        e = (n == 0) ? exp0.pop_front() : exp1.pop_front();
                        check($sformatf("rdata_m%0d", n), 64'(rd), 64'(e.rdata));
                        check($sformatf("err_m%0d", n), 64'(er), 64'(e.err));
                        if (e.cyc >= 0) check($sformatf("ack_cycle_m%0d", n), 64'(cyc), 64'(e.cyc));
                    end
                    last_m  = n;
                    cur_gnt = -1;
                end else if (er === 1'b1) begin
                    checks++; errors++;
                    $display("FAIL err_without_ack m%0d: got err=1 required 0", n);
                end
            end
            prev_s = sb.strb;
        end
        prev_strb     = {m1b.strb, m0b.strb};
        prev_addr[0]  = m0b.addr;  prev_addr[1]  = m1b.addr;
        prev_wr[0]    = m0b.wr;    prev_wr[1]    = m1b.wr;
        prev_wdata[0] = m0b.wdata; prev_wdata[1] = m1b.wdata;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end

    task automatic random_master(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(m, 1'($urandom_range(0, 1)), {1'(m), 7'($urandom)}, 8'($urandom), -1, 0);
        end
    endtask

    initial begin
        m0b.strb = 0; m0b.wr = 0; m0b.addr = 0; m0b.wdata = 0;
        m1b.strb = 0; m1b.wr = 0; m1b.addr = 0; m1b.wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        last_rdata[0] = 0; last_rdata[1] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_bus", 64'({sb.strb, sb.wr, sb.addr, sb.wdata}), 64'(0));
        check("rst_m0", 64'({m0b.ack, m0b.err, m0b.rdata}), 64'(0));
        check("rst_m1", 64'({m1b.ack, m1b.err, m1b.rdata}), 64'(0));
        rst = 1'b1;

        // First write: slave bus one edge after the request is sampled
        fixed_lat = 2;
        fork
            issue(0, 1'b1, 8'h10, 8'hA5, 2, 0);
            begin
                @(posedge clk); @(posedge clk); #2;
                check("req_to_slave", 64'({sb.strb, sb.addr, sb.wdata}), 64'({1'b1, 8'h10, 8'hA5}));
            end
        join

        // Read return to m1
        fixed_lat = 3;
        issue(1, 1'b0, 8'h10, 8'h00, 3, 0);
        check("m1_read_a5", 64'(m1b.rdata), 64'(8'hA5));

        // Simultaneous requests from reset
        @(posedge clk); #1; rst = 1'b0; last_rdata[0] = 0; last_rdata[1] = 0;
        @(posedge clk); #1; rst = 1'b1;
        fixed_lat = 1;
        glog.delete();
        fork
            begin issue(0, 1'b0, 8'h20, 8'h00, -1, 0); issue(0, 1'b0, 8'h21, 8'h00, -1, 0); end
            begin issue(1, 1'b0, 8'hA0, 8'h00, -1, 0); issue(1, 1'b0, 8'hA1, 8'h00, -1, 0); end
        join
        check("rr_count", 64'(glog.size()), 64'(4));
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check($sformatf("rr_order_%0d", i), 64'(glog[i]), 64'(i % 2));

        // Mid-transaction reset
        slave_mode = 0;
        @(posedge clk); #1;
        m0b.wr = 0; m0b.addr = 8'h33; m0b.strb = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("mid_rst_pre_strb", 64'(sb.strb), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_strb_async", 64'(sb.strb), 64'(0));
        check("mid_rst_acks", 64'({m0b.ack, m1b.ack}), 64'(0));
        check("mid_rst_rdata", 64'(m1b.rdata), 64'(0));
        m0b.strb = 1'b0;
        last_rdata[0] = 0; last_rdata[1] = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        slave_mode = 1;
        glog.delete();
        fork
            issue(0, 1'b0, 8'h40, 8'h00, -1, 0);
            issue(1, 1'b0, 8'hC0, 8'h00, -1, 0);
        join
        check("post_rst_tie_m0", 64'(glog.size() > 0 ? glog[0] : -1), 64'(0));

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog expiry, then an ack landing on the limit cycle
        slave_mode = 0;
        issue(0, 1'b0, 8'h50, 8'h00, TIMEOUT - 1, 1);
        slave_mode = 1;
        fixed_lat  = TIMEOUT - 1;
        issue(0, 1'b0, 8'h51, 8'h00, TIMEOUT - 1, 0);
`endif

        // Randomized traffic on disjoint address halves
        fixed_lat = -1;
        fork
            random_master(0, 40);
            random_master(1, 40);
        join

        repeat (5) @(posedge clk);
        #1;
        check("exp0_drained", 64'(exp0.size()), 64'(0));
        check("exp1_drained", 64'(exp1.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
